// File: rtl/bf_sweep_checker_pkg.sv
// Shared types, constants and the golden reference for the De Morgan gate sweep checker.
package bf_sweep_checker_pkg;

   localparam int ERR_W = 4;
   localparam int VEC_W = 3;

   localparam logic [VEC_W-1:0] VEC_LAST = 3'd7;

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      SAMPLE,
      DONE
   } state_t;

   // Expected value of both gate outputs for inputs a, b, c.
   function automatic logic bf_golden(input logic a, input logic b, input logic c);
      return ~((a | b) & c);
   endfunction

endpackage

// File: rtl/bf_sweep_checker.sv
// Sweeps the gate inputs through all 8 vectors, samples both gate outputs after a
// settle interval and reports pass/fail, the failing-vector count and the first failure.
module bf_sweep_checker
   import bf_sweep_checker_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_out,
   output logic             b_out,
   output logic             c_out,
   input  logic             d_in,
   input  logic             e_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             first_fail_valid,
   output logic [VEC_W-1:0] first_fail_vec
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(8);

   state_t           state;
   logic [VEC_W-1:0] vec;
   logic [3:0]       settle;
   logic             exp_bit;
   logic             vec_fail;
   logic [ERR_W-1:0] err_next;

   // Judge the current vector; only consumed while in SAMPLE.
   always_comb begin
      exp_bit  = bf_golden(vec[2], vec[1], vec[0]);
      vec_fail = (d_in != exp_bit) || (e_in != exp_bit);
      err_next = err_count;
      if (vec_fail && (err_count != ERR_MAX)) begin
         err_next = err_count + ERR_W'(1);
      end
   end

   // Sweep sequencer with registered gate drive and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= IDLE;
         vec                     <= '0;
         settle                  <= '0;
         {a_out, b_out, c_out}   <= '0;
         busy                    <= 1'b0;
         done                    <= 1'b0;
         pass                    <= 1'b0;
         err_count               <= '0;
         first_fail_valid        <= 1'b0;
         first_fail_vec          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state                 <= APPLY;
                  vec                   <= '0;
                  settle                <= '0;
                  {a_out, b_out, c_out} <= '0;
                  busy                  <= 1'b1;
                  pass                  <= 1'b0;
                  err_count             <= '0;
                  first_fail_valid      <= 1'b0;
                  first_fail_vec        <= '0;
               end
            end
            APPLY: begin
               settle <= settle + 4'd1;
               if (settle == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               err_count <= err_next;
               if (vec_fail && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_vec   <= vec;
               end
               if (vec == VEC_LAST) begin
                  // pass is taken from the count including this last vector so it
                  // is already valid in the cycle that carries the done pulse
                  state                 <= DONE;
                  {a_out, b_out, c_out} <= '0;
                  done                  <= 1'b1;
                  pass                  <= (err_next == '0);
               end else begin
                  state                 <= APPLY;
                  vec                   <= vec + VEC_W'(1);
                  {a_out, b_out, c_out} <= vec + VEC_W'(1);
                  settle                <= '0;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bf_sweep_checker.sv
// Bench for bf_sweep_checker: two instances (settle 2 and settle 1), each with a
// behavioural gate carrying selectable faults, checked against a cycle-index model.
module tb_bf_sweep_checker;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst       [2];
   logic       start     [2];
   logic       a_w       [2];
   logic       b_w       [2];
   logic       c_w       [2];
   logic       d_w       [2];
   logic       e_w       [2];
   logic       busy_o    [2];
   logic       done_o    [2];
   logic       pass_o    [2];
   logic [3:0] err_o     [2];
   logic       ffv_o     [2];
   logic [2:0] ffvec_o   [2];

   // fault modes: 0 good gate, 1 E stuck-at-0, 2 D stuck-at-1, 3 D and E inverted at vec 7
   int         fault     [2];
   logic       glitch_en [2];
   logic       noise_d   [2];
   logic       noise_e   [2];
   logic       in_samp_q [2];

   // model state: cyc is the cycle index within a sweep (0 when idle)
   int         cyc       [2];
   int         m_err     [2];
   logic       m_ffv     [2];
   logic [2:0] m_ffvec   [2];
   logic       m_pass    [2];

   int         n_vec = 0;
   int         n_bad = 0;
   bit         chk_en = 1'b0;

   function automatic int s_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int last_cyc(input int i);
      return 8 * (s_of(i) + 1) + 1;
   endfunction

   function automatic bit is_sample(input int i, input int c);
      return (c >= 1) && (c < last_cyc(i)) && (((c - 1) % (s_of(i) + 1)) == s_of(i));
   endfunction

   function automatic int vec_at(input int i, input int c);
      return ((c >= 1) && (c < last_cyc(i))) ? (c - 1) / (s_of(i) + 1) : 0;
   endfunction

   function automatic logic gate_d(input int m, input logic [2:0] v);
      logic good;
      good = ~((v[2] & v[0]) | (v[1] & v[0]));
      if (m == 2) return 1'b1;
      if (m == 3 && v == 3'd7) return ~good;
      return good;
   endfunction

   function automatic logic gate_e(input int m, input logic [2:0] v);
      logic good;
      good = (~v[2] & ~v[1]) | ~v[0];
      if (m == 1) return 1'b0;
      if (m == 3 && v == 3'd7) return ~good;
      return good;
   endfunction

   function automatic bit vec_fails(input int m, input int v);
      logic [7:0] tbl;
      logic [2:0] vv;
      logic       ex;
      tbl = 8'h57;
      vv  = v[2:0];
      ex  = tbl[vv];
      return (gate_d(m, vv) != ex) || (gate_e(m, vv) != ex);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign d_w[g] = gate_d(fault[g], {a_w[g], b_w[g], c_w[g]}) ^ (glitch_en[g] & noise_d[g] & ~in_samp_q[g]);
      assign e_w[g] = gate_e(fault[g], {a_w[g], b_w[g], c_w[g]}) ^ (glitch_en[g] & noise_e[g] & ~in_samp_q[g]);

      bf_sweep_checker #(.SETTLE_CYCLES(g == 0 ? 2 : 1)) u_dut (
         .clk              (clk),
         .rst              (rst[g]),
         .start            (start[g]),
         .a_out            (a_w[g]),
         .b_out            (b_w[g]),
         .c_out            (c_w[g]),
         .d_in             (d_w[g]),
         .e_in             (e_w[g]),
         .busy             (busy_o[g]),
         .done             (done_o[g]),
         .pass             (pass_o[g]),
         .err_count        (err_o[g]),
         .first_fail_valid (ffv_o[g]),
         .first_fail_vec   (ffvec_o[g])
      );
   end

   task automatic chk(input string name, input int i, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL d%0d %s: got %0d expected %0d at %0t", i, name, act, exp, $time);
      end
   endtask

   // Reference model advanced on every rising edge.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst[i]) begin
            cyc[i] = 0; m_err[i] = 0; m_ffv[i] = 1'b0; m_ffvec[i] = 3'd0; m_pass[i] = 1'b0;
         end else if (cyc[i] == 0) begin
            if (start[i]) begin
               cyc[i] = 1; m_err[i] = 0; m_ffv[i] = 1'b0; m_ffvec[i] = 3'd0; m_pass[i] = 1'b0;
            end
         end else begin
            if (is_sample(i, cyc[i])) begin
               int v;
               v = vec_at(i, cyc[i]);
               if (vec_fails(fault[i], v)) begin
                  m_err[i]++;
                  if (!m_ffv[i]) begin
                     m_ffv[i]   = 1'b1;
                     m_ffvec[i] = v[2:0];
                  end
               end
               if (v == 7) m_pass[i] = (m_err[i] == 0);
            end
            cyc[i] = (cyc[i] == last_cyc(i)) ? 0 : cyc[i] + 1;
         end
      end
   end

   // Noise generation and per-cycle comparison against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         in_samp_q[i] = is_sample(i, cyc[i]);
         noise_d[i]   = 1'($urandom_range(0, 1));
         noise_e[i]   = 1'($urandom_range(0, 1));
         if (chk_en) begin
            chk("busy", i, busy_o[i], int'(cyc[i] != 0));
            chk("done", i, done_o[i], int'(cyc[i] == last_cyc(i)));
            chk("abc", i, {a_w[i], b_w[i], c_w[i]}, vec_at(i, cyc[i]));
            chk("err_count", i, err_o[i], m_err[i]);
            chk("first_fail_valid", i, ffv_o[i], m_ffv[i]);
            if (m_ffv[i]) chk("first_fail_vec", i, ffvec_o[i], m_ffvec[i]);
            chk("pass", i, pass_o[i], m_pass[i]);
         end
      end
   end

   // Pulse (or hold) start; returns at the negedge of the done cycle, k = cycle index.
   task automatic run_sweep(input int i, input bit hold, output int k);
      start[i] = 1'b1;
      @(negedge clk);
      if (!hold) start[i] = 1'b0;
      k = 1;
      while (!done_o[i] && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", i, done_o[i], 1);
   endtask

   task automatic wait_done(input int i);
      int k;
      k = 0;
      while (!done_o[i] && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", i, done_o[i], 1);
   endtask

   initial begin
      int k;
      int dcount;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1; start[i] = 1'b0; fault[i] = 0; glitch_en[i] = 1'b0;
         noise_d[i] = 1'b0; noise_e[i] = 1'b0; in_samp_q[i] = 1'b0;
         cyc[i] = 0; m_err[i] = 0; m_ffv[i] = 1'b0; m_ffvec[i] = 3'd0; m_pass[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", 0, busy_o[0], 0);
      chk("rst_err", 0, err_o[0], 0);
      chk("rst_pass", 1, pass_o[1], 0);
      repeat (2) @(negedge clk);

      // good gate, S=2
      run_sweep(0, 1'b0, k);
      chk("done_cycle_s2", 0, k, 25);
      chk("good_pass", 0, pass_o[0], 1);
      chk("good_err", 0, err_o[0], 0);
      chk("good_ffv", 0, ffv_o[0], 0);
      repeat (3) @(negedge clk);

      // E stuck-at-0, then restart one cycle after done
      fault[0] = 1;
      run_sweep(0, 1'b0, k);
      chk("esa0_err", 0, err_o[0], 5);
      chk("esa0_pass", 0, pass_o[0], 0);
      chk("esa0_ffv", 0, ffv_o[0], 1);
      chk("esa0_ffvec", 0, ffvec_o[0], 0);
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      chk("restart_busy", 0, busy_o[0], 1);
      chk("restart_err_cleared", 0, err_o[0], 0);
      wait_done(0);
      chk("restart_err", 0, err_o[0], 5);
      repeat (2) @(negedge clk);

      // D stuck-at-1, S=1
      fault[1] = 2;
      run_sweep(1, 1'b0, k);
      chk("done_cycle_s1", 1, k, 17);
      chk("dsa1_err", 1, err_o[1], 3);
      chk("dsa1_ffvec", 1, ffvec_o[1], 3);
      repeat (2) @(negedge clk);

      // start held through the whole sweep and the DONE cycle
      fault[0] = 0;
      run_sweep(0, 1'b1, k);
      chk("held_done_cycle", 0, k, 25);
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      chk("held_single_sweep", 0, busy_o[0], 0);
      repeat (2) @(negedge clk);

      // mid-sweep reset in cycle 10
      fault[0] = 1;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_rst_err", 0, err_o[0], 3);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("post_rst_busy", 0, busy_o[0], 0);
      chk("post_rst_err", 0, err_o[0], 0);
      chk("post_rst_abc", 0, {a_w[0], b_w[0], c_w[0]}, 0);
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done_o[0]) dcount++;
      end
      chk("no_done_after_rst", 0, dcount, 0);

      // D and E both wrong at vec 7 only
      fault[0] = 3;
      run_sweep(0, 1'b0, k);
      chk("v7_err", 0, err_o[0], 1);
      chk("v7_ffvec", 0, ffvec_o[0], 7);
      repeat (5) @(negedge clk);
      chk("v7_pass_held", 0, pass_o[0], 0);

      // randomized traffic: start pulses, occasional resets, fault changes while idle, glitches
      repeat (1500) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            start[i]     = ($urandom_range(0, 7) == 0);
            rst[i]       = ($urandom_range(0, 199) == 0);
            glitch_en[i] = 1'($urandom_range(0, 1));
            if (cyc[i] == 0) fault[i] = int'($urandom_range(0, 3));
         end
      end
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0; rst[i] = 1'b0;
      end
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
